// File: rtl/burst_incre_seq.sv
// rtl/burst_incre_seq.sv - burst increment sequencer feeding the burst increment value path
// Optional retrigger in RUN/FLUSH enabled by defining BURST_INCRE_RETRIG_EN.
module burst_incre_seq #(
   parameter int VPATH_DEPTH = 4
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        Trig,
   input  logic [15:0] Cycles,
   input  logic [15:0] Incre,
   output logic [15:0] Dout,
   output logic        Busy,
   output logic        Valid_D,
   output logic        Done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_t;

   state_t                 state;
   logic                   trig_q;
   logic [15:0]            cnt;
   logic [3:0]             flush_cnt;
   logic                   valid_int;
   logic [VPATH_DEPTH-1:0] valid_sr;
   logic                   edge_ok;
   logic                   start;

   assign edge_ok = Trig & ~trig_q & (Cycles != 16'd0);

   always_comb begin
      start = 1'b0;
`ifdef BURST_INCRE_RETRIG_EN
      start = edge_ok;
`else
      start = edge_ok && (state == IDLE);
`endif
   end

   // valid_int rides alongside Dout; the shift register mirrors the value path depth
   assign Valid_D = valid_sr[VPATH_DEPTH-1];

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state     <= IDLE;
         trig_q    <= 1'b1;
         cnt       <= 16'd0;
         flush_cnt <= 4'd0;
         valid_int <= 1'b0;
         valid_sr  <= '0;
         Dout      <= 16'd0;
         Busy      <= 1'b0;
         Done      <= 1'b0;
      end else begin
         trig_q   <= Trig;
         valid_sr <= {valid_sr[VPATH_DEPTH-2:0], valid_int};
         Done     <= 1'b0;
         if (start) begin
            state     <= RUN;
            cnt       <= Cycles;
            Dout      <= Incre;
            valid_int <= 1'b1;
            Busy      <= 1'b1;
         end else begin
            case (state)
               RUN: begin
                  if (cnt == 16'd1) begin
                     state     <= FLUSH;
                     Dout      <= 16'd0;
                     valid_int <= 1'b0;
                     flush_cnt <= 4'd0;
                  end else begin
                     cnt <= cnt - 16'd1;
                  end
               end
               FLUSH: begin
                  if (flush_cnt == 4'(VPATH_DEPTH - 1)) begin
                     state <= IDLE;
                     Busy  <= 1'b0;
                     Done  <= 1'b1;
                  end else begin
                     flush_cnt <= flush_cnt + 4'd1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_burst_incre_seq.sv
// tb/tb_burst_incre_seq.sv - directed self-checking bench for burst_incre_seq
module tb_burst_incre_seq;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        Trig;
   logic [15:0] Cycles;
   logic [15:0] Incre;
   logic [15:0] Dout;
   logic        Busy;
   logic        Valid_D;
   logic        Done;

   int pass_cnt  = 0;
   int total_cnt = 0;

   burst_incre_seq #(.VPATH_DEPTH(4)) dut (
      .Clock   (Clock),
      .Reset   (Reset),
      .Trig    (Trig),
      .Cycles  (Cycles),
      .Incre   (Incre),
      .Dout    (Dout),
      .Busy    (Busy),
      .Valid_D (Valid_D),
      .Done    (Done)
   );

   always #5 Clock = ~Clock;

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic test_reset();
      logic [18:0] got;
      Reset = 1'b1; Trig = 1'b0; Cycles = 16'd0; Incre = 16'd0;
      step(); step();
      got = {Dout, Busy, Valid_D, Done};
      total_cnt++;
      if (got !== 19'd0) $display("FAIL reset_held got=%h expected=%h", got, 19'd0);
      else pass_cnt++;
      @(negedge Clock) Reset = 1'b0;
      step(); step();
      got = {Dout, Busy, Valid_D, Done};
      total_cnt++;
      if (got !== 19'd0) $display("FAIL reset_released got=%h expected=%h", got, 19'd0);
      else pass_cnt++;
   endtask

   // k counts clocks after the accepted edge; k=1 is the first Dout word
   task automatic test_basic();
      logic [18:0] got, exp;
      Cycles = 16'd3; Incre = 16'h0100; Trig = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         step();
         got = {Dout, Busy, Valid_D, Done};
         exp = {(k <= 3) ? 16'h0100 : 16'h0000, 1'(k <= 7), 1'(k >= 5 && k <= 7), 1'(k == 8)};
         total_cnt++;
         if (got !== exp) $display("FAIL basic k=%0d got=%h expected=%h", k, got, exp);
         else pass_cnt++;
         if (k == 1) begin Trig = 1'b0; Cycles = 16'd9; Incre = 16'hFFFF; end
      end
   endtask

   task automatic test_zero_cycles();
      logic [18:0] got;
      Cycles = 16'd0; Incre = 16'h5555; Trig = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         step();
         got = {Dout, Busy, Valid_D, Done};
         total_cnt++;
         if (got !== 19'd0) $display("FAIL zero_cycles k=%0d got=%h expected=%h", k, got, 19'd0);
         else pass_cnt++;
      end
      Trig = 1'b0;
      step();
   endtask

   task automatic test_retrig();
      logic [18:0] got, exp;
      logic [15:0] exp_dout;
      Cycles = 16'd4; Incre = 16'h0010; Trig = 1'b1;
      for (int k = 1; k <= 14; k++) begin
         step();
         if (k <= 2) exp_dout = 16'h0010;
`ifdef BURST_INCRE_RETRIG_EN
         else if (k <= 4) exp_dout = 16'h0020;
`else
         else if (k <= 4) exp_dout = 16'h0010;
`endif
         else exp_dout = 16'h0000;
         got = {Dout, Busy, Valid_D, Done};
         exp = {exp_dout, 1'(k <= 8), 1'(k >= 5 && k <= 8), 1'(k == 9)};
         total_cnt++;
         if (got !== exp) $display("FAIL retrig k=%0d got=%h expected=%h", k, got, exp);
         else pass_cnt++;
         if (k == 1) Trig = 1'b0;
         if (k == 2) begin Trig = 1'b1; Cycles = 16'd2; Incre = 16'h0020; end
         if (k == 3) Trig = 1'b0;
      end
   endtask

   task automatic test_back_to_back();
      logic [18:0] got, exp;
      logic [15:0] exp_dout;
      Cycles = 16'd2; Incre = 16'h00AA; Trig = 1'b1;
      for (int k = 1; k <= 15; k++) begin
         step();
         if (k <= 2) exp_dout = 16'h00AA;
         else if (k == 8) exp_dout = 16'h00BB;
         else exp_dout = 16'h0000;
         got = {Dout, Busy, Valid_D, Done};
         exp = {exp_dout, 1'(k <= 6 || (k >= 8 && k <= 12)),
                1'((k >= 5 && k <= 6) || k == 12), 1'(k == 7 || k == 13)};
         total_cnt++;
         if (got !== exp) $display("FAIL back_to_back k=%0d got=%h expected=%h", k, got, exp);
         else pass_cnt++;
         if (k == 1) Trig = 1'b0;
         if (k == 7) begin Trig = 1'b1; Cycles = 16'd1; Incre = 16'h00BB; end
         if (k == 8) Trig = 1'b0;
      end
   endtask

   task automatic test_async_reset();
      logic [18:0] got, exp;
      Cycles = 16'd4; Incre = 16'h4444; Trig = 1'b1;
      step();
      step();
      got = {Dout, Busy, Valid_D, Done};
      exp = {16'h4444, 1'b1, 1'b0, 1'b0};
      total_cnt++;
      if (got !== exp) $display("FAIL abort_pre got=%h expected=%h", got, exp);
      else pass_cnt++;
      #2 Reset = 1'b1;
      #1;
      got = {Dout, Busy, Valid_D, Done};
      total_cnt++;
      if (got !== 19'd0) $display("FAIL abort_immediate got=%h expected=%h", got, 19'd0);
      else pass_cnt++;
      step(); step();
      @(negedge Clock) Reset = 1'b0;
      // Trig stays high through reset release: must not start a burst
      for (int k = 1; k <= 12; k++) begin
         step();
         got = {Dout, Busy, Valid_D, Done};
         total_cnt++;
         if (got !== 19'd0) $display("FAIL held_trig k=%0d got=%h expected=%h", k, got, 19'd0);
         else pass_cnt++;
      end
      Trig = 1'b0;
      step();
      Trig = 1'b1; Cycles = 16'd1; Incre = 16'h1234;
      for (int k = 1; k <= 8; k++) begin
         step();
         got = {Dout, Busy, Valid_D, Done};
         exp = {(k == 1) ? 16'h1234 : 16'h0000, 1'(k <= 5), 1'(k == 5), 1'(k == 6)};
         total_cnt++;
         if (got !== exp) $display("FAIL post_reset k=%0d got=%h expected=%h", k, got, exp);
         else pass_cnt++;
         if (k == 1) Trig = 1'b0;
      end
   endtask

   task automatic test_max_cycles();
      logic [18:0] got, exp;
      Cycles = 16'hFFFF; Incre = 16'h7777; Trig = 1'b1;
      step();
      Trig = 1'b0;
      repeat (300) step();
      got = {Dout, Busy, Valid_D, Done};
      exp = {16'h7777, 1'b1, 1'b1, 1'b0};
      total_cnt++;
      if (got !== exp) $display("FAIL max_cycles got=%h expected=%h", got, exp);
      else pass_cnt++;
      Reset = 1'b1;
      step();
      @(negedge Clock) Reset = 1'b0;
      step();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_cycles();
      test_retrig();
      test_back_to_back();
      test_async_reset();
      test_max_cycles();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/burst_incre_seq.md
# burst_incre_seq

Burst increment sequencer for the arbitrary function generator. On a trigger edge it issues a programmed 16-bit phase increment for exactly `Cycles` clocks into the 4-stage burst increment value path, then drives zero. It also carries a matching 4-stage valid pipeline, so `Valid_D` and `Done` align with the word leaving that path. It is the producer end of the burst increment path; its `Dout` connects directly to the path's `Din`.

## Interface
- `VPATH_DEPTH`, 4: pipeline depth of the downstream value path; sets the valid-delay length and the FLUSH duration.
- `Clock` input 1: single clock; all state updates on the rising edge.
- `Reset` input 1: asynchronous, active-high reset.
- `Trig` input 1: burst trigger, level input; rising edge detected internally.
- `Cycles` input 16: burst length in clocks; sampled on the accepted trigger edge.
- `Incre` input 16: phase increment issued during the burst; sampled on the accepted trigger edge.
- `Dout` output 16: increment word to the value path; `Incre` during RUN, 0 otherwise.
- `Busy` output 1: high in RUN and FLUSH.
- `Valid_D` output 1: valid delayed `VPATH_DEPTH` clocks; high exactly while a burst word exits the value path.
- `Done` output 1: single-cycle pulse on the clock after the last `Valid_D`.

## Operation
- Reset values: `Dout`=0, `Busy`=0, `Valid_D`=0, `Done`=0, state IDLE, burst counter 0, valid shift register all 0, `Trig_q`=1.
- `Trig_q` resetting to 1 prevents a trigger held high through reset from firing.
- Edge detect: accepted edge = `Trig` & ~`Trig_q` while in IDLE, and only if `Cycles` != 0. `Trig_q` registers `Trig` every clock.
- IDLE -> RUN on an accepted edge. `Cycles` and `Incre` are latched at that edge; later input changes have no effect on the current burst.
- RUN: `Dout` = latched `Incre`; internal valid = 1; counter decrements by 1 per clock; RUN -> FLUSH when the counter reaches 1.
- FLUSH: `Dout`=0; valid=0; stays exactly `VPATH_DEPTH` clocks (4-bit flush counter), then -> IDLE with `Done` pulsed.
- `Trig` edges during RUN or FLUSH are ignored (default build).
- An edge with `Cycles`=0 is ignored; the block stays in IDLE with no outputs changing.
- Counter is 16-bit unsigned; `Cycles`=16'hFFFF gives 65535 words with no wrap.
- `Reset` mid-burst immediately forces all reset values and drops in-flight valids. `Done` is not generated for an aborted burst.

## Timing
- Accepted edge sampled at clock n, with burst length N:
  - `Dout`=`Incre` and `Busy`=1 for clocks n+1..n+N.
  - FLUSH, with `Busy`=1, covers n+N+1..n+N+4.
  - `Valid_D`=1 for n+5..n+N+4.
  - `Done`=1 at n+N+5, with `Busy`=0 and the state in IDLE.
- Earliest next accepted edge is sampled at n+N+5, the `Done` clock. Its first word appears at n+N+6, so bursts are back-to-back with a 1-clock zero gap.
- Latency from trigger sample to first `Dout` word: 1 clock. Latency to first `Valid_D`: 5 clocks.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `BURST_INCRE_RETRIG_EN` defined:
  - A `Trig` rising edge in RUN or FLUSH with `Cycles` != 0 restarts RUN at the next clock.
  - `Cycles` and `Incre` are re-latched at that edge.
  - The valid shift register is not cleared, so words already in flight still produce `Valid_D`.
  - `Done` fires only after the final burst drains.
- Undefined: retrigger edges in RUN and FLUSH are ignored, as described in Operation.

## Test plan
- `Cycles`=3, `Incre`=16'h0100, edge sampled at clock 10 -> `Dout`=16'h0100 at 11–13 and 0 at 14; `Valid_D` high at 15–17; `Done` high only at 18; `Busy` high at 11–17.
- `Cycles`=0 with a trigger edge -> `Busy`, `Dout`, `Valid_D` and `Done` stay 0 for 20 clocks.
- `Cycles`=5, second `Trig` edge at the 2nd RUN clock (macro off) -> exactly 5 words; `Done` at n+10; no second burst.
- `Reset` asserted asynchronously at the 2nd RUN clock of a 4-word burst -> all outputs 0 immediately; no `Done`; `Valid_D` never rises.
- `Trig` held high through `Reset` deassertion -> no burst. A later low-then-high transition starts a normal burst.
- Macro on: `Cycles`=4, `Incre`=16'h0010; retrigger at 2nd RUN clock with `Cycles`=2, `Incre`=16'h0020 -> `Dout` shows 16'h0010 for 2 clocks then 16'h0020 for 2 clocks; `Valid_D` high for 4 contiguous clocks; one `Done`.
